// File: rtl/mem_arbiter.sv
// Two-port read arbiter in front of a single-port memory with LAT-cycle read latency.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0 wins).
module mem_arbiter #(
    parameter int AW  = 12,
    parameter int DW  = 16,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_cs,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic          win_q, win_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          pick;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On a tie the port that did not win last time goes next.
    assign pick = (req0 && req1) ? ~last_q : ~req0;
`else
    assign pick = ~req0;
`endif

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    win_d   = pick;
                    addr_d  = pick ? addr1 : addr0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 3'(LAT);
                state_d = WAIT;
`ifdef ARB_ROUND_ROBIN_EN
                last_d  = win_q;
`endif
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (win_q) rdata1_d = mem_dout;
                    else       rdata0_d = mem_dout;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low combinationally so they read zero for the whole reset pulse.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rvalid0  = 1'b0;
        rvalid1  = 1'b0;
        mem_cs   = 1'b0;
        mem_addr = '0;
        busy     = 1'b0;
        rdata0   = '0;
        rdata1   = '0;
        if (!rst) begin
            busy    = (state_q != IDLE);
            mem_cs  = (state_q == ISSUE);
            gnt0    = (state_q == ISSUE) && !win_q;
            gnt1    = (state_q == ISSUE) &&  win_q;
            rvalid0 = (state_q == RESP)  && !win_q;
            rvalid1 = (state_q == RESP)  &&  win_q;
            rdata0  = rdata0_q;
            rdata1  = rdata1_q;
            if (state_q == ISSUE) mem_addr = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            win_q    <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

endmodule
